// File: rtl/data_ram.sv
// Byte-addressable, word-organised data RAM with a single-request valid/ready port,
// a configurable read latency and a zeroing sweep after every reset.
module data_ram #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the request side is ready only in IDLE, and the response is held until rsp_ready.

  localparam int NWORDS = 2 ** (AWIDTH - 2);

  localparam logic [1:0] S_CLEAR  = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [AWIDTH-3:0] CLR_LAST = (AWIDTH - 2)'(NWORDS - 1);
  localparam logic [AWIDTH-3:0] CLR_ONE  = (AWIDTH - 2)'(1);
  localparam logic [1:0]        LAT_INIT = 2'(RD_LAT - 1);

  logic [1:0]        state;
  logic [AWIDTH-3:0] clr_cnt;
  logic [1:0]        lat_cnt;

  logic [AWIDTH-1:0] a_addr;
  logic [2:0]        a_funct3;
  logic              a_we;
  logic              a_err;

  logic [DWIDTH-1:0] mem [NWORDS];

  logic              accept;
  logic              req_fault;
  logic              st_we;
  logic              clr_we;
  logic [DWIDTH-1:0] wmask;
  logic [DWIDTH-1:0] wdata_rep;
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] byte_sh;
  logic [DWIDTH-1:0] half_sh;
  logic [DWIDTH-1:0] load_val;

  // Illegal encodings and misaligned halfword/word accesses both report rsp_err.
  function automatic logic access_fault(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic illegal;
    logic misaligned;
    illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    misaligned = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    return illegal || misaligned;
  endfunction

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;

  assign accept    = req_valid && req_ready;
  assign req_fault = access_fault(req_we, req_funct3, req_addr[1:0]);
  assign st_we     = rst_n && accept && req_we && !req_fault;
  assign clr_we    = rst_n && (state == S_CLEAR);

  always_comb begin
    wmask     = '0;
    wdata_rep = '0;
    case (req_funct3[1:0])
      2'b00: begin
        wmask     = DWIDTH'(32'h0000_00FF) << {req_addr[1:0], 3'b000};
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wmask     = DWIDTH'(32'h0000_FFFF) << {req_addr[1], 4'b0000};
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        wmask     = '1;
        wdata_rep = req_wdata;
      end
    endcase
  end

  // Stores land at the acceptance edge, so any later load sees them.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (st_we) begin
      mem[req_addr[AWIDTH-1:2]] <= (mem[req_addr[AWIDTH-1:2]] & ~wmask) | (wdata_rep & wmask);
    end
  end

  assign rd_word = mem[a_addr[AWIDTH-1:2]];
  assign byte_sh = rd_word >> {a_addr[1:0], 3'b000};
  assign half_sh = rd_word >> {a_addr[1], 4'b0000};

  always_comb begin
    load_val = '0;
    case (a_funct3)
      3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_val = {24'h0, byte_sh[7:0]};
      3'b001:  load_val = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_val = {16'h0, half_sh[15:0]};
      3'b010:  load_val = rd_word;
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      lat_cnt   <= '0;
      a_addr    <= '0;
      a_funct3  <= '0;
      a_we      <= 1'b0;
      a_err     <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + CLR_ONE;
          if (clr_cnt == CLR_LAST) state <= S_IDLE;
        end
        S_IDLE: begin
          if (req_valid) begin
            a_addr   <= req_addr;
            a_funct3 <= req_funct3;
            a_we     <= req_we;
            a_err    <= req_fault;
            lat_cnt  <= LAT_INIT;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (lat_cnt == 2'd0) begin
            rsp_err   <= a_err;
            rsp_rdata <= (a_we || a_err) ? '0 : load_val;
            state     <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: reset/clear timing, directed vector table, latency/backpressure,
// reset-in-flight, and random traffic against a byte-array reference model.
module tb_data_ram;

  localparam int AW     = 12;
  localparam int RD_LAT = 3;
  localparam int NBYTES = 2 ** AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mdl [NBYTES];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [$];

  data_ram #(.AWIDTH(AW), .DWIDTH(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a flat byte array, little-endian, sizes and extension by arithmetic.
  task automatic model_access(input logic we, input logic [2:0] f3, input int addr,
                              input logic [31:0] wdata, output logic [31:0] rd,
                              output logic err);
    int size;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) ||
          ((size == 2) && (addr % 2 != 0)) || ((size == 4) && (addr % 4 != 0));
    rd = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) mdl[addr + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v + (32'(mdl[addr + i]) << (8 * i));
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      rd = v;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!req_ready && cnt < 5000);
  endtask

  // One full transaction; while the response is held, a competing store is presented
  // and must be ignored.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] r0;
    logic e0;
    rd = 32'h0;
    err = 1'b0;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      check("req_ready_busy", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      n++;
    end
    check("rsp_latency", 32'(n), 32'(RD_LAT));
    if (!rsp_valid) return;
    r0 = rsp_rdata;
    e0 = rsp_err;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 12'h010; req_wdata = 32'h5555_5555;
      check("hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold_rdata", rsp_rdata, r0);
      check("hold_err", {31'h0, rsp_err}, {31'h0, e0});
      check("hold_req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    rd = rsp_rdata;
    err = rsp_err;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", {31'h0, rsp_valid}, 32'h0);
    check("back_to_idle", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    int cnt;
    int n;
    logic [31:0] rd, mrd;
    logic err, merr;
    logic we;
    logic [2:0] f3;
    logic [11:0] addr;
    logic [31:0] wdata;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);

    rst_n = 1'b1;
    wait_clear(cnt);
    check("clear_cycles", 32'(cnt), 32'd1024);

    for (int a = 0; a < NBYTES; a += 4) begin
      do_req(1'b0, 3'b010, 12'(a), 32'h0, 0, rd, err);
      check("sweep_lw", rd, 32'h0);
    end

    // Directed vectors, applied in order from a cleared memory.
    tbl.push_back('{1'b1, 3'b010, 12'h010, 32'h1122_3344, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 12'h013, 32'h0,         32'h0000_0011, 1'b0});
    tbl.push_back('{1'b0, 3'b100, 12'h010, 32'h0,         32'h0000_0044, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 12'h012, 32'h0,         32'h0000_1122, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 12'h010, 32'h0,         32'h1122_3344, 1'b0});
    tbl.push_back('{1'b1, 3'b000, 12'h021, 32'h0000_0080, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 12'h021, 32'h0,         32'hFFFF_FF80, 1'b0});
    tbl.push_back('{1'b0, 3'b100, 12'h021, 32'h0,         32'h0000_0080, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 12'h020, 32'h0,         32'h0000_8000, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 12'h002, 32'h0,         32'h0000_0000, 1'b1});
    tbl.push_back('{1'b1, 3'b001, 12'h005, 32'h0000_ABCD, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 3'b010, 12'h004, 32'h0,         32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 3'b010, 12'hFFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 12'hFFC, 32'h0,         32'hCAFE_F00D, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 12'hFFF, 32'h0,         32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 3'b011, 12'h000, 32'h0,         32'h0000_0000, 1'b1});
    tbl.push_back('{1'b1, 3'b100, 12'h010, 32'h0000_00FF, 32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 3'b010, 12'h010, 32'h0,         32'h1122_3344, 1'b0});
    tbl.push_back('{1'b1, 3'b001, 12'h012, 32'h0000_8001, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 12'h012, 32'h0,         32'hFFFF_8001, 1'b0});
    tbl.push_back('{1'b0, 3'b101, 12'h012, 32'h0,         32'h0000_8001, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 12'h010, 32'h0,         32'h8001_3344, 1'b0});
    tbl.push_back('{1'b0, 3'b111, 12'h000, 32'h0,         32'h0000_0000, 1'b1});
    tbl.push_back('{1'b0, 3'b110, 12'h000, 32'h0,         32'h0000_0000, 1'b1});

    foreach (tbl[i]) begin
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, rd, err);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
      model_access(tbl[i].we, tbl[i].f3, int'(tbl[i].addr), tbl[i].wdata, mrd, merr);
    end

    // Backpressure: response held 5 cycles with a competing store presented.
    do_req(1'b0, 3'b010, 12'h010, 32'h0, 5, rd, err);
    check("hold_lw_rdata", rd, 32'h8001_3344);
    do_req(1'b0, 3'b010, 12'h010, 32'h0, 0, rd, err);
    check("ignored_store", rd, 32'h8001_3344);

    // Random traffic against the reference model.
    for (int t = 0; t < 400; t++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b001;
        4, 5:    f3 = 3'b010;
        6:       f3 = 3'b100;
        7:       f3 = 3'b101;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 7) == 0) addr = 12'hFF0 + 12'($urandom_range(0, 15));
      else addr = 12'($urandom_range(0, 63));
      wdata = $urandom;
      model_access(we, f3, int'(addr), wdata, mrd, merr);
      exp_q.push_back({merr, mrd[30:0]} ^ {1'b0, 31'h0} | (merr ? 32'h0 : 32'h0));
      exp_q.push_back(mrd);
      do_req(we, f3, addr, wdata, $urandom_range(0, 2), rd, err);
      check("rand_err", {31'h0, err}, {31'h0, exp_q[0][31]});
      void'(exp_q.pop_front());
      check("rand_rdata", rd, exp_q.pop_front());
    end

    // Reset while a store response is pending, then reset again mid-sweep.
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 12'h040; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre_reset_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("mid_rst_rdata", rsp_rdata, 32'h0);
    check("mid_rst_err", {31'h0, rsp_err}, 32'h0);
    check("mid_rst_state", {30'h0, dbg_state}, 32'h0);
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    check("partial_clear_busy", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear(cnt);
    check("reclear_cycles", 32'(cnt), 32'd1024);
    model_clear();
    do_req(1'b0, 3'b010, 12'h040, 32'h0, 0, rd, err);
    check("post_reset_lw40", rd, 32'h0);
    do_req(1'b0, 3'b010, 12'h010, 32'h0, 0, rd, err);
    check("post_reset_lw10", rd, 32'h0);
    do_req(1'b0, 3'b010, 12'hFFC, 32'h0, 0, rd, err);
    check("post_reset_lwffc", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
